// File: rtl/step_pulse_gen.sv
// Single-step clock generator for a CPU: a debounced push-button issues one step clock pulse,
// and a free-run level input issues steps at a fixed period.
module step_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned RUN_PERIOD      = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       run,
  output logic       step_clk,
  output logic       step_pulse,
  output logic [7:0] step_count,
  output logic       busy
);

  // The shared counter must reach the larger of the debounce and run-period terminal values.
  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > RUN_PERIOD) ? DEBOUNCE_CYCLES : RUN_PERIOD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned PwW    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RunLast = CntW'(RUN_PERIOD - 1);
  localparam logic [PwW-1:0]  PwLast  = PwW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StFire,
    StReleaseWait
  } state_e;

  logic            btn_meta_q, btn_s_q;
  logic            run_meta_q, run_s_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PwW-1:0]  pw_q, pw_d;
  logic            from_run_q, from_run_d;
  logic            step_clk_q, step_clk_d;
  logic            step_pulse_q, step_pulse_d;
  logic [7:0]      step_count_q, step_count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= button;
      btn_s_q    <= btn_meta_q;
      run_meta_q <= run;
      run_s_q    <= run_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pw_d       = pw_q;
    from_run_d = from_run_q;

    unique case (state_q)
      StIdle: begin
        if (run_s_q) begin
          if (cnt_q == RunLast) begin
            state_d    = StFire;
            cnt_d      = '0;
            pw_d       = '0;
            from_run_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (btn_s_q) begin
            state_d = StPressDb;
          end
        end
      end
      StPressDb: begin
        if (!btn_s_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d    = StFire;
          cnt_d      = '0;
          pw_d       = '0;
          from_run_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFire: begin
        // Pulse width depends only on pw_q, so input activity cannot alter it.
        if (pw_q == PwLast) begin
          state_d = from_run_q ? StIdle : StReleaseWait;
          pw_d    = '0;
          cnt_d   = '0;
        end else begin
          pw_d = pw_q + 1'b1;
        end
      end
      StReleaseWait: begin
        if (btn_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == DbLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        pw_d    = '0;
      end
    endcase

    step_clk_d   = (state_d == StFire);
    step_pulse_d = (state_d == StFire) && (state_q != StFire);
    step_count_d = step_count_q + {7'd0, step_pulse_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pw_q         <= '0;
      from_run_q   <= 1'b0;
      step_clk_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      step_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pw_q         <= pw_d;
      from_run_q   <= from_run_d;
      step_clk_q   <= step_clk_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_clk   = step_clk_q;
  assign step_pulse = step_pulse_q;
  assign step_count = step_count_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5000, number of consecutive stable clk cycles required to accept a button press or release.
REQ-002 Parameter PULSE_CYCLES, default 16, number of clk cycles step_clk stays high per step.
REQ-003 Parameter RUN_PERIOD, default 50000, clk cycles between automatic steps in free-run mode.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; ports are named clk and reset.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 button  input  1  raw asynchronous push-button, active-high, bouncing.
REQ-008 run  input  1  asynchronous free-run request, level, active-high.
REQ-009 step_clk  output  1  registered single-step clock driving the CPU clock input.
REQ-010 step_pulse  output  1  one-cycle strobe, high on the clk cycle step_clk rises.
REQ-011 step_count  output  8  number of steps issued, modulo 256.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 button and run SHALL each pass through a 2-flop synchronizer (btn_s, run_s); all decisions use only the synchronized values.
REQ-014 FSM states: IDLE, PRESS_DB, FIRE, RELEASE_WAIT; one debounce/period counter, one pulse-width counter.
REQ-015 IDLE, run_s=1: period counter increments each cycle; at RUN_PERIOD-1 -> FIRE (run origin), counter cleared; btn_s ignored.
REQ-016 IDLE, run_s=0, btn_s=1: -> PRESS_DB, counter cleared; period counter cleared whenever run_s=0.
REQ-017 PRESS_DB: counter increments while btn_s=1; btn_s=0 on any cycle -> IDLE, no step (bounce rejected); counter reaching DEBOUNCE_CYCLES-1 with btn_s=1 -> FIRE (button origin).
REQ-018 FIRE: step_clk=1 for exactly PULSE_CYCLES cycles, then step_clk=0 and -> RELEASE_WAIT (button origin) or IDLE (run origin).
REQ-019 RELEASE_WAIT: counter increments while btn_s=0, cleared on any btn_s=1; reaching DEBOUNCE_CYCLES-1 -> IDLE.
REQ-020 A held button SHALL produce exactly one step regardless of hold duration.
REQ-021 step_pulse and the step_count increment SHALL occur on the single cycle of FIRE entry; step_count wraps 255 -> 0.
REQ-022 Changes of run or button during FIRE SHALL NOT shorten or extend the pulse.
REQ-023 run_s rising during PRESS_DB or RELEASE_WAIT SHALL take effect only after return to IDLE.
REQ-024 Press latency: with button stable high, step_clk rises DEBOUNCE_CYCLES+2 clk edges after the first edge sampling button=1.
REQ-025 busy = (state != IDLE), combinational from the state register.
REQ-026 step_clk SHALL be driven directly from a flop, never gated from clk.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, step_clk=0, step_pulse=0, step_count=0, busy=0, all counters and synchronizer flops 0.
REQ-028 Reset asserted mid-FIRE SHALL drop step_clk at once with no step_count change; operation resumes from IDLE on the first clk edge after reset=1.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, RUN_PERIOD=10)
REQ-029 Clean press: button high 20 cycles -> step_clk high exactly 2 cycles starting 6 edges after first sample, one step_pulse, step_count 0->1.
REQ-030 Bounce: button toggles 1,0,1,0 each 2 cycles then low -> no step_clk, step_count stays 0, busy returns 0.
REQ-031 Release bounce: after a step, button toggles 0/1 for 10 cycles then stable low 4+ cycles -> still exactly one step; second clean press -> step_count=2.
REQ-032 Free-run: run high 100 cycles -> step_pulse every 12 cycles (10 count + 2 FIRE), 8 steps; button presses meanwhile add none.
REQ-033 Wrap: 256 steps via run mode -> step_count returns to 0, step_pulse still asserted on the 256th.
REQ-034 Reset mid-pulse: reset=0 on second FIRE cycle -> step_clk=0, step_count=0, busy=0 immediately; next clean press yields step_count=1.
